// File: rtl/pc_unit_ras_pkg.sv
// rtl/pc_unit_ras_pkg.sv - shared types and helpers for the PC unit with return-address stack
package pc_unit_pkg;

  // Next-PC source chosen by the priority encoder
  typedef enum logic [2:0] {
    SEL_SEQ,
    SEL_BR,
    SEL_JMP,
    SEL_CALL,
    SEL_RET
  } pc_sel_e;

  // Widest field the sign-extension helper handles
  localparam int SEXT_MAX_W = 32;

  // Sign-extend the low src_w bits of v to SEXT_MAX_W bits; callers truncate to their width
  function automatic logic [SEXT_MAX_W-1:0] sext(input logic [SEXT_MAX_W-1:0] v,
                                                 input int src_w);
    logic [SEXT_MAX_W-1:0] t;
    t = v << (SEXT_MAX_W - src_w);
    return $unsigned($signed(t) >>> (SEXT_MAX_W - src_w));
  endfunction

endpackage

// File: rtl/pc_unit_ras_if.sv
// rtl/pc_unit_ras_if.sv - decoder-to-PC-unit strobe and status bundle
interface pc_unit_ras_if #(
  parameter int PC_W    = 16,
  parameter int DISP_W  = 8,
  parameter int LABEL_W = 11
);

  logic               stall;
  logic               branch;
  logic [DISP_W-1:0]  disp;
  logic               jmp;
  logic [LABEL_W-1:0] label;
  logic               call;
  logic               ret;
  logic [PC_W-1:0]    pc;
  logic               ras_empty;
  logic               ras_full;
  logic               ras_err;

  // Decoder side: drives control strobes, observes PC and stack status
  modport master (
    output stall, branch, disp, jmp, label, call, ret,
    input  pc, ras_empty, ras_full, ras_err
  );

  // PC unit side
  modport slave (
    input  stall, branch, disp, jmp, label, call, ret,
    output pc, ras_empty, ras_full, ras_err
  );

endinterface

// File: rtl/ras_stack.sv
// rtl/ras_stack.sv - circular return-address LIFO that overwrites its oldest entry when full
module ras_stack #(
  parameter int W     = 16,
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             push,
  input  logic             pop,
  input  logic [W-1:0]     din,
  output logic [W-1:0]     dout,
  output logic [CNT_W-1:0] count,
  output logic             overflow,
  output logic             underflow
);

  logic [PTR_W-1:0] top_q, top_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [W-1:0]     mem_q [DEPTH];
  logic [W-1:0]     mem_d [DEPTH];
  logic             full;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign dout  = mem_q[top_q];
  assign count = count_q;

  // Pointer/count update; a push while full wraps onto the oldest slot, a pop while empty is a no-op
  always_comb begin
    top_d     = top_q;
    count_d   = count_q;
    mem_d     = mem_q;
    overflow  = 1'b0;
    underflow = 1'b0;
    if (push) begin
      top_d        = top_q + PTR_W'(1);
      mem_d[top_d] = din;
      if (full) begin
        overflow = 1'b1;
      end else begin
        count_d = count_q + CNT_W'(1);
      end
    end else if (pop) begin
      if (count_q == '0) begin
        underflow = 1'b1;
      end else begin
        top_d   = top_q - PTR_W'(1);
        count_d = count_q - CNT_W'(1);
      end
    end
  end

  // Pointer and occupancy registers; entries themselves need no reset
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      top_q   <= '0;
      count_q <= '0;
    end else begin
      top_q   <= top_d;
      count_q <= count_d;
    end
  end

  // Entry storage
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/pc_unit_ras.sv
// rtl/pc_unit_ras.sv - program counter with relative jumps, call/return and stall
module pc_unit_ras
  import pc_unit_pkg::*;
#(
  parameter int PC_W      = 16,
  parameter int DISP_W    = 8,
  parameter int LABEL_W   = 11,
  parameter int RAS_DEPTH = 4
) (
  input  logic          clk,
  input  logic          clr_n,
  pc_unit_ras_if.slave  bus
);

  localparam int CNT_W = $clog2(RAS_DEPTH + 1);

  pc_sel_e          sel;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic             err_q, err_d;
  logic [PC_W-1:0]  pc_inc;
  logic [PC_W-1:0]  disp_ext;
  logic [PC_W-1:0]  label_ext;
  logic             push, pop;
  logic [PC_W-1:0]  ras_dout;
  logic [CNT_W-1:0] ras_count;
  logic             ras_ovf, ras_unf;
  logic             empty;

  assign empty     = (ras_count == '0);
  assign pc_inc    = pc_q + PC_W'(1);
  assign disp_ext  = PC_W'(sext(SEXT_MAX_W'(bus.disp), DISP_W));
  assign label_ext = PC_W'(sext(SEXT_MAX_W'(bus.label), LABEL_W));

  // Strobe priority: ret > call > jmp > branch > sequential
  always_comb begin
    sel = SEL_SEQ;
    if (bus.ret) begin
      sel = SEL_RET;
    end else if (bus.call) begin
      sel = SEL_CALL;
    end else if (bus.jmp) begin
      sel = SEL_JMP;
    end else if (bus.branch) begin
      sel = SEL_BR;
    end
  end

  // Stack is only touched when not stalled, so stall also masks error detection
  always_comb begin
    push = !bus.stall && (sel == SEL_CALL);
    pop  = !bus.stall && (sel == SEL_RET);
  end

  ras_stack #(
    .W     (PC_W),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .clr_n     (clr_n),
    .push      (push),
    .pop       (pop),
    .din       (pc_inc),
    .dout      (ras_dout),
    .count     (ras_count),
    .overflow  (ras_ovf),
    .underflow (ras_unf)
  );

  // Next-PC mux; a return on an empty stack falls through to the sequential address
  always_comb begin
    pc_d  = pc_inc;
    err_d = err_q | ras_ovf | ras_unf;
    case (sel)
      SEL_RET:  pc_d = empty ? pc_inc : ras_dout;
      SEL_CALL: pc_d = pc_q + label_ext;
      SEL_JMP:  pc_d = pc_q + label_ext;
      SEL_BR:   pc_d = pc_q + disp_ext;
      default:  pc_d = pc_inc;
    endcase
    if (bus.stall) begin
      pc_d = pc_q;
    end
  end

  // PC and sticky error registers; reset beats stall and every strobe
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      pc_q  <= '0;
      err_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      err_q <= err_d;
    end
  end

  assign bus.pc        = pc_q;
  assign bus.ras_err   = err_q;
  assign bus.ras_empty = empty;
  assign bus.ras_full  = (ras_count == CNT_W'(RAS_DEPTH));

endmodule

// File: tb/tb_pc_unit_ras.sv
// tb/tb_pc_unit_ras.sv - directed vector bench for pc_unit_ras
module tb_pc_unit_ras;

  typedef struct {
    logic        clr_n;
    logic        stall;
    logic        branch;
    logic [7:0]  disp;
    logic        jmp;
    logic [10:0] label;
    logic        call;
    logic        ret;
    logic [15:0] e_pc;
    logic        e_empty;
    logic        e_full;
    logic        e_err;
  } vec_t;

  logic clk;
  logic clr_n;
  int   n_checks;
  int   n_pass;
  vec_t tbl[$];

  pc_unit_ras_if #(.PC_W(16), .DISP_W(8), .LABEL_W(11)) bus ();

  pc_unit_ras #(.PC_W(16), .DISP_W(8), .LABEL_W(11), .RAS_DEPTH(4)) dut (
    .clk   (clk),
    .clr_n (clr_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(logic cn, logic st, logic br, logic [7:0] d, logic j,
                              logic [10:0] l, logic c, logic r, logic [15:0] p,
                              logic e, logic f, logic er);
    vec_t v;
    v.clr_n = cn; v.stall = st; v.branch = br; v.disp = d; v.jmp = j; v.label = l;
    v.call = c; v.ret = r; v.e_pc = p; v.e_empty = e; v.e_full = f; v.e_err = er;
    return v;
  endfunction

  task automatic chk(string name, int idx, logic [15:0] act, logic [15:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
  endtask

  task automatic apply(vec_t v, int idx);
    @(negedge clk);
    clr_n      = v.clr_n;
    bus.stall  = v.stall;
    bus.branch = v.branch;
    bus.disp   = v.disp;
    bus.jmp    = v.jmp;
    bus.label  = v.label;
    bus.call   = v.call;
    bus.ret    = v.ret;
    @(posedge clk);
    #1;
    chk("pc", idx, bus.pc, v.e_pc);
    chk("ras_empty", idx, 16'(bus.ras_empty), 16'(v.e_empty));
    chk("ras_full", idx, 16'(bus.ras_full), 16'(v.e_full));
    chk("ras_err", idx, 16'(bus.ras_err), 16'(v.e_err));
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    clr_n = 1'b0; bus.stall = 1'b0; bus.branch = 1'b0; bus.disp = '0;
    bus.jmp = 1'b0; bus.label = '0; bus.call = 1'b0; bus.ret = 1'b0;

    // reset, free run, branch/jump priority
    tbl.push_back(mk(0,0,0,8'h00,0,11'h000,0,0, 16'h0000,1,0,0));
    for (int i = 1; i <= 6; i++)
      tbl.push_back(mk(1,0,0,8'h00,0,11'h000,0,0, 16'(i),1,0,0));
    tbl.push_back(mk(1,0,1,8'hFE,0,11'h000,0,0, 16'h0004,1,0,0));
    tbl.push_back(mk(1,0,0,8'h00,1,11'd15,0,0,  16'h0013,1,0,0));
    tbl.push_back(mk(1,0,1,8'h10,1,11'd3,0,0,   16'h0016,1,0,0));
    tbl.push_back(mk(1,0,0,8'h00,1,11'h7FA,0,0, 16'h0010,1,0,0));
    // single call / return
    tbl.push_back(mk(1,0,0,8'h00,0,11'h020,1,0, 16'h0030,0,0,0));
    tbl.push_back(mk(1,0,0,8'h00,0,11'h000,0,0, 16'h0031,0,0,0));
    tbl.push_back(mk(1,0,0,8'h00,0,11'h000,0,0, 16'h0032,0,0,0));
    tbl.push_back(mk(1,0,0,8'h00,0,11'h000,0,1, 16'h0011,1,0,0));
    // five nested calls, overflow on the fifth
    tbl.push_back(mk(1,0,0,8'h00,0,11'h010,1,0, 16'h0021,0,0,0));
    tbl.push_back(mk(1,0,0,8'h00,0,11'h010,1,0, 16'h0031,0,0,0));
    tbl.push_back(mk(1,0,0,8'h00,0,11'h010,1,0, 16'h0041,0,0,0));
    tbl.push_back(mk(1,0,0,8'h00,0,11'h010,1,0, 16'h0051,0,1,0));
    tbl.push_back(mk(1,0,0,8'h00,0,11'h010,1,0, 16'h0061,0,1,1));
    // LIFO returns, then underflow
    tbl.push_back(mk(1,0,0,8'h00,0,11'h000,0,1, 16'h0052,0,0,1));
    tbl.push_back(mk(1,0,0,8'h00,0,11'h000,0,1, 16'h0042,0,0,1));
    tbl.push_back(mk(1,0,0,8'h00,0,11'h000,0,1, 16'h0032,0,0,1));
    tbl.push_back(mk(1,0,0,8'h00,0,11'h000,0,1, 16'h0022,1,0,1));
    tbl.push_back(mk(1,0,0,8'h00,0,11'h000,0,1, 16'h0023,1,0,1));
    // call+ret on empty stack: ret wins, call not pushed
    tbl.push_back(mk(1,0,0,8'h00,0,11'h010,1,1, 16'h0024,1,0,1));
    // reset together with stall and call
    tbl.push_back(mk(0,1,0,8'h00,0,11'd5,1,0,   16'h0000,1,0,0));

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

    // stall held with call for three cycles, then released
    for (int i = 0; i < 3; i++) apply(mk(1,1,0,8'h00,0,11'd5,1,0, 16'h0000,1,0,0), 100 + i);
    apply(mk(1,0,0,8'h00,0,11'd5,1,0, 16'h0005,0,0,0), 103);
    apply(mk(1,0,0,8'h00,0,11'd0,0,0, 16'h0006,0,0,0), 104);
    apply(mk(1,1,0,8'h00,0,11'd0,0,1, 16'h0006,0,0,0), 105);
    apply(mk(1,0,0,8'h00,0,11'd0,0,1, 16'h0001,1,0,0), 106);
    apply(mk(1,1,0,8'h00,0,11'd0,0,1, 16'h0001,1,0,0), 107);
    apply(mk(1,0,1,8'h80,0,11'd0,0,0, 16'hFF81,1,0,0), 108);

    // wrap-around at the top of the address space
    apply(mk(0,0,0,8'h00,0,11'h000,0,0, 16'h0000,1,0,0), 200);
    apply(mk(1,0,0,8'h00,1,11'h7FF,0,0, 16'hFFFF,1,0,0), 201);
    apply(mk(1,0,0,8'h00,0,11'h000,0,0, 16'h0000,1,0,0), 202);
    apply(mk(1,0,0,8'h00,0,11'h000,0,0, 16'h0001,1,0,0), 203);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pc_unit_ras.md
# pc_unit_ras

Parametrised program-counter unit for the single-cycle RISC core; successor to the fixed 16-bit PC circuit. It adds configurable widths, a stall input, PC-relative jumps, and subroutine call/return backed by an on-chip return-address stack (RAS). It sits at the front of the datapath, drives the instruction-memory address, and takes control strobes from the decoder.

## Interface
- PC_W, 16, PC / instruction-address width
- DISP_W, 8, branch displacement width (two's complement)
- LABEL_W, 11, jump/call offset width (two's complement)
- RAS_DEPTH, 4, return-stack entries (power of two, ≥2)

- clk  in  1  rising-edge clock, single domain
- clr_n  in  1  synchronous active-low reset
- stall  in  1  hold PC and stack this cycle
- branch  in  1  taken-branch strobe
- disp  in  DISP_W  branch displacement
- jmp  in  1  unconditional jump strobe
- label  in  LABEL_W  jump/call offset
- call  in  1  jump to label offset and push return address
- ret  in  1  pop return address into PC
- pc  out  PC_W  current PC (registered)
- ras_empty  out  1  stack holds 0 entries
- ras_full  out  1  stack holds RAS_DEPTH entries
- ras_err  out  1  sticky: overflow or underflow occurred since reset

## Operation
- Next-PC, priority highest first, evaluated only when stall=0:
  - ret: pc ← top of stack; pop.
  - call: pc ← pc + sext(label); push pc+1.
  - jmp: pc ← pc + sext(label).
  - branch: pc ← pc + sext(disp).
  - none: pc ← pc + 1.
- Lower-priority strobes asserted together with a higher one are ignored (e.g. call+ret → ret only; jmp+branch → jmp).
- All arithmetic is modulo 2^PC_W; offsets are sign-extended to PC_W, so wrap-around from 0xFFFF+1 → 0x0000 (PC_W=16) is legal and silent.
- RAS is a circular LIFO with a count of 0..RAS_DEPTH.
  - Overflow: call when full overwrites the oldest entry; count stays RAS_DEPTH; ras_err ← 1.
  - Underflow: ret when empty → pc ← pc+1, no pop, ras_err ← 1.
- stall=1: pc, stack contents, count, and ras_err all hold; every strobe is ignored, including error detection.
- ras_empty and ras_full are decoded from the registered count.

## Timing
- Single-cycle: strobes sampled at rising edge N; the new pc is visible after edge N; a pushed entry can be popped by a ret at edge N+1.
- Reset: clr_n=0 at an edge → pc=0, count=0, ras_err=0, ras_empty=1, ras_full=0; stack contents are don't-care. Reset overrides stall and all strobes, including mid-call.
- No combinational path from inputs to outputs.

## Structure
- Package pc_unit_pkg: next-PC select enum (SEL_SEQ, SEL_BR, SEL_JMP, SEL_CALL, SEL_RET), plus a sign-extension function parametrised by the source width.
- Sub-module ras_stack (params W, DEPTH; ports clk, clr_n, push, pop, din, dout, count): circular storage with a top pointer; it reports overflow and underflow pulses to the parent, which owns ras_err.
- Top level: priority encoder, adders, PC register.

## Test plan
- Reset, then free-run 6 cycles → pc 0,1,2,3,4,5,6; ras_empty=1, ras_err=0.
- At pc=6: branch=1, disp=8'hFE → pc=4. Next cycle jmp=1, label=11'd15 → pc=19. Then jmp=1 with branch=1 simultaneously → jump taken, branch ignored.
- At pc=0x0010: call with label=0x020 → pc=0x0030. Two cycles later (pc=0x0032): ret → pc=0x0011, ras_empty=1.
- Five nested calls with RAS_DEPTH=4 → ras_full=1 and ras_err=1 after the 5th; four rets return the last four return addresses in LIFO order; a fifth ret → pc+1 with ras_empty=1.
- stall=1 for 3 cycles with call=1 held → pc and count unchanged, ras_err unchanged. Deassert stall → call executes once.
- Assert clr_n=0 together with stall=1 mid-sequence → pc=0, ras_empty=1, ras_err=0 on the next edge. PC_W=16 with pc=0xFFFF free-running → pc=0x0000.
